// File: rtl/sd_response_receiver.sv
// SD CMD-line response receiver: waits for the start bit, captures a 48/136-bit
// frame MSB first, and reports CRC7, end-bit and timeout status.
module sd_response_receiver #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         ENABLE,
  input  logic         LONG,
  input  logic         CHECK_CRC,
  input  logic         IN,
  output logic [135:0] DATA,
  output logic         BUSY,
  output logic         FINISH,
  output logic         TIMEOUT,
  output logic         CRC_ERR,
  output logic         END_ERR
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  state_t          state;
  logic            long_q;
  logic            crc_en_q;
  logic [7:0]      bit_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [6:0]      crc;

  logic [135:0]    data_nxt;
  logic            last_bit;
  logic            crc_use;
  logic            fb;
  logic [6:0]      crc_nxt;

  assign data_nxt = {DATA[134:0], IN};
  assign last_bit = long_q ? (bit_cnt == 8'd135) : (bit_cnt == 8'd47);
  // CRC span excludes start bit (zero anyway) and, for R2, the 8-bit header.
  assign crc_use  = long_q ? (bit_cnt >= 8'd8 && bit_cnt <= 8'd127) : (bit_cnt <= 8'd39);
  assign fb       = crc[6] ^ IN;
  assign crc_nxt  = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      long_q   <= 1'b0;
      crc_en_q <= 1'b0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      crc      <= '0;
      DATA     <= '0;
      BUSY     <= 1'b0;
      FINISH   <= 1'b0;
      TIMEOUT  <= 1'b0;
      CRC_ERR  <= 1'b0;
      END_ERR  <= 1'b0;
    end else begin
      FINISH <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            long_q   <= LONG;
            crc_en_q <= CHECK_CRC;
            DATA     <= '0;
            TIMEOUT  <= 1'b0;
            CRC_ERR  <= 1'b0;
            END_ERR  <= 1'b0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            crc      <= '0;
            BUSY     <= 1'b1;
            state    <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (!IN) begin
            DATA    <= data_nxt;
            bit_cnt <= 8'd1;
            state   <= RECEIVE;
          end else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            TIMEOUT <= 1'b1;
            BUSY    <= 1'b0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RECEIVE: begin
          DATA    <= data_nxt;
          bit_cnt <= bit_cnt + 8'd1;
          if (crc_use) crc <= crc_nxt;
          if (last_bit) begin
            // CRC register is final well before the CRC field arrives.
            CRC_ERR <= crc_en_q && (data_nxt[7:1] != crc);
            END_ERR <= !IN;
            BUSY    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          FINISH <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_response_receiver.sv
// Directed bench for sd_response_receiver; hand-computed frames and timings.
module tb_sd_response_receiver;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         ENABLE = 1'b0;
  logic         LONG = 1'b0;
  logic         CHECK_CRC = 1'b0;
  logic         IN = 1'b1;
  logic [135:0] DATA;
  logic         BUSY, FINISH, TIMEOUT, CRC_ERR, END_ERR;

  int vectors = 0;
  int errs = 0;
  int fin_cnt = 0;
  int f0;

  localparam logic [135:0] LONG_FRAME = 136'h3F_00000000000000000000_48000001AA_87;

  sd_response_receiver #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .LONG(LONG),
    .CHECK_CRC(CHECK_CRC), .IN(IN), .DATA(DATA), .BUSY(BUSY),
    .FINISH(FINISH), .TIMEOUT(TIMEOUT), .CRC_ERR(CRC_ERR), .END_ERR(END_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (FINISH === 1'b1) fin_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept edge e happens inside; returns just after it with IN idle high.
  task automatic accept(input logic lng, input logic chkcrc);
    ENABLE = 1'b1; LONG = lng; CHECK_CRC = chkcrc; IN = 1'b1;
    step();
    ENABLE = 1'b0;
  endtask

  // Drives n bits MSB first; optional ENABLE pulses at bits poke and poke+20.
  task automatic send(input logic [135:0] f, input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      IN = f[n-1-i];
      ENABLE = (poke > 0) && (i == poke || i == poke + 20);
      step();
    end
    IN = 1'b1;
    ENABLE = 1'b0;
  endtask

  task automatic result(input string tag, input logic [135:0] d,
                        input logic to, input logic ce, input logic ee);
    chk({tag, "_fin_early"}, FINISH, 1'b0);
    step();
    chk({tag, "_fin"}, FINISH, 1'b1);
    chk({tag, "_data"}, DATA, d);
    chk({tag, "_timeout"}, TIMEOUT, to);
    chk({tag, "_crc_err"}, CRC_ERR, ce);
    chk({tag, "_end_err"}, END_ERR, ee);
    chk({tag, "_busy"}, BUSY, 1'b0);
    step();
    chk({tag, "_fin_drop"}, FINISH, 1'b0);
    chk({tag, "_data_hold"}, DATA, d);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_data", DATA, '0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_fin", FINISH, 1'b0);
    chk("rst_to", TIMEOUT, 1'b0);
    chk("rst_crc", CRC_ERR, 1'b0);
    chk("rst_end", END_ERR, 1'b0);
    RESET_N = 1'b1;
    step();

    // Short valid: idle high at e..e+2, start at e+3, FINISH after e+51
    f0 = fin_cnt;
    accept(1'b0, 1'b1);
    chk("short_busy", BUSY, 1'b1);
    step(); step();
    send(136'h48000001AA87, 48, 0);
    result("short", 136'h48000001AA87, 1'b0, 1'b0, 1'b0);
    chk("short_pulses", 136'(fin_cnt - f0), 136'd1);

    // CRC error, then same frame with checking off, then bad end bit
    accept(1'b0, 1'b1);
    send(136'h400000000097, 48, 0);
    result("crc_bad", 136'h400000000097, 1'b0, 1'b1, 1'b0);
    accept(1'b0, 1'b0);
    send(136'h400000000097, 48, 0);
    result("crc_off", 136'h400000000097, 1'b0, 1'b0, 1'b0);
    accept(1'b0, 1'b1);
    send(136'h400000000094, 48, 0);
    result("end_bad", 136'h400000000094, 1'b0, 1'b0, 1'b1);

    // Timeout with ENABLE held: FINISH after e+65, re-accept after e+66
    ENABLE = 1'b1; LONG = 1'b0; CHECK_CRC = 1'b1; IN = 1'b1;
    step();
    repeat (64) step();
    chk("to_fin_early", FINISH, 1'b0);
    step();
    chk("to_fin", FINISH, 1'b1);
    chk("to_flag", TIMEOUT, 1'b1);
    chk("to_crc", CRC_ERR, 1'b0);
    chk("to_end", END_ERR, 1'b0);
    chk("to_data", DATA, '0);
    chk("to_busy_done", BUSY, 1'b0);
    step();
    chk("to_reaccept_busy", BUSY, 1'b1);
    chk("to_reaccept_fin", FINISH, 1'b0);
    chk("to_reaccept_clr", TIMEOUT, 1'b0);
    ENABLE = 1'b0;
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;

    // Start bit on the 64th sample is a start, not a timeout
    accept(1'b0, 1'b1);
    repeat (63) step();
    send(136'h400000000095, 48, 0);
    result("to_edge", 136'h400000000095, 1'b0, 1'b0, 1'b0);

    // Long R2: header 0x3F excluded from CRC; FINISH after s+136
    accept(1'b1, 1'b1);
    send(LONG_FRAME, 136, 0);
    result("long", LONG_FRAME, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame at bit 20
    f0 = fin_cnt;
    accept(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      IN = (48'h48000001AA87 >> (47 - i)) & 1'b1;
      step();
    end
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    IN = 1'b1;
    chk("mid_rst_data", DATA, '0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_fin", FINISH, 1'b0);
    chk("mid_rst_to", TIMEOUT, 1'b0);
    chk("mid_rst_crc", CRC_ERR, 1'b0);
    chk("mid_rst_end", END_ERR, 1'b0);
    repeat (40) step();
    chk("mid_rst_nofin", 136'(fin_cnt - f0), 136'd0);
    chk("mid_rst_idle", BUSY, 1'b0);
    accept(1'b0, 1'b1);
    send(136'h400000000095, 48, 0);
    result("after_rst", 136'h400000000095, 1'b0, 1'b0, 1'b0);

    // ENABLE pulses and LONG/CHECK_CRC changes during RECEIVE are ignored
    f0 = fin_cnt;
    accept(1'b0, 1'b1);
    LONG = 1'b1; CHECK_CRC = 1'b0;
    send(136'h400000000097, 48, 5);
    result("ign_en", 136'h400000000097, 1'b0, 1'b1, 1'b0);
    step();
    chk("ign_en_pulses", 136'(fin_cnt - f0), 136'd1);
    chk("ign_en_idle", BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sd_response_receiver.md
# sd_response_receiver

Receives the card's response on the SD CMD line after a command has been shifted out by the command sender, and is enabled by the same controller FSM. It waits a bounded number of clocks for the start bit, then captures a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. It checks the CRC7 and end bit and presents the captured frame with status flags. It samples the line on the rising edge of CLK, opposite to the sender's falling-edge drive.

## Interface
- TIMEOUT_CYCLES, 64: maximum consecutive idle-high samples tolerated before the start bit (SD N_CR limit).
- CLK  input  1  SD clock; all logic on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- ENABLE  input  1  start-listening request; sampled only in IDLE.
- LONG  input  1  1 = 136-bit R2 response, 0 = 48-bit; latched on ENABLE acceptance.
- CHECK_CRC  input  1  1 = check CRC7 (0 for R3); latched on ENABLE acceptance.
- IN  input  1  CMD line from card (idle high).
- DATA  output  136  captured frame, right-aligned; 48-bit frames occupy [47:0] with [135:48]=0.
- BUSY  output  1  high in WAIT_START and RECEIVE.
- FINISH  output  1  one-cycle pulse when a result is available.
- TIMEOUT  output  1  no start bit within TIMEOUT_CYCLES.
- CRC_ERR  output  1  CRC7 mismatch (only when CHECK_CRC latched 1).
- END_ERR  output  1  last bit sampled as 0.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE: ENABLE=1 → latch LONG/CHECK_CRC, clear DATA and flags, clear wait counter → WAIT_START.
- WAIT_START: each cycle sample IN. IN=0 → start bit; shift 0 into DATA, bit counter=1 → RECEIVE. IN=1 → increment wait counter; on the TIMEOUT_CYCLES-th consecutive 1 → TIMEOUT=1 → DONE.
- RECEIVE: shift IN into DATA LSB each cycle (MSB first), increment bit counter; at count 48 (short) or 136 (long) → DONE.
- CRC7 polynomial x^7+x^3+1, register init 0, serial update on sampled bits. Covers frame bits [47:8] (short) or [127:8] (long; start, transmission and 6 reserved bits excluded). Compare against frame bits [7:1].
- On completion: CRC_ERR = CHECK_CRC && mismatch; END_ERR = (bit0==0). Both 0 on timeout.
- DONE: FINISH=1 for exactly one cycle → IDLE. DATA and flags hold until the next accepted ENABLE or reset.
- ENABLE in any state other than IDLE is ignored. Transmission bit and reserved bits are not checked.
- Bit counter 8 bits, wait counter $clog2(TIMEOUT_CYCLES+1) bits; neither wraps, both are cleared on entry to WAIT_START.

## Timing
- Reset (RESET_N=0 at a rising edge) → next cycle: state IDLE, DATA=0, BUSY=0, FINISH=0, TIMEOUT=0, CRC_ERR=0, END_ERR=0. Overrides any state, including mid-frame; the partial frame is discarded.
- ENABLE sampled at edge e → BUSY=1 from e; first IN sample at edge e+1.
- Start bit sampled at edge s → last bit at s+47 (short) / s+135 (long). FINISH, flags and final DATA valid after edge s+48 / s+136.
- IN=1 for all samples e+1..e+TIMEOUT_CYCLES → FINISH and TIMEOUT high after edge e+TIMEOUT_CYCLES+1.
- IN=0 on the TIMEOUT_CYCLES-th sample counts as the start bit, not a timeout.
- ENABLE held high through DONE → accepted again in IDLE the cycle after FINISH; no back-to-back accept in DONE.

## Test plan
- Short, valid: ENABLE, LONG=0, CHECK_CRC=1, 3 idle-high cycles then frame 0x48000001AA87 → DATA=0x48000001AA87, FINISH pulse 51 cycles after ENABLE edge, all flags 0.
- CRC error: frame 0x400000000097 → CRC_ERR=1, END_ERR=0. Same frame with CHECK_CRC=0 → CRC_ERR=0. Frame 0x400000000094 → END_ERR=1, CRC_ERR=0.
- Timeout: ENABLE, IN held 1 → FINISH with TIMEOUT=1 exactly 65 cycles after ENABLE edge (default). Start bit on the 64th sample → normal reception, TIMEOUT=0.
- Long R2: LONG=1, frame of 0x3F header + 120-bit CID with correct internal CRC7 and end bit 1 → DATA[135:0] matches, flags 0, FINISH 136 cycles after start bit.
- Reset mid-frame: RESET_N low at bit 20 → all outputs 0 next cycle, no FINISH. A new ENABLE with 0x400000000095 then completes with flags 0.
- ENABLE pulses during RECEIVE are ignored; the frame completes unchanged with a single FINISH pulse.
